// File: rtl/fft_frame_sequencer.sv
// In-place radix-2 DIT FFT sequencer: loads a frame bit-reversed, drives an external
// butterfly one pair per clock across all stages, then streams bins out in natural order.
module fft_frame_sequencer #(
  parameter int N_POINTS = 16,
  parameter int LOG2N    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [15:0]        sample_real,
  input  logic [15:0]        sample_imag,
  output logic               sample_ready,
  output logic [LOG2N-2:0]   twiddle_addr,
  input  logic [15:0]        twiddle_real,
  input  logic [15:0]        twiddle_imag,
  output logic [15:0]        bf_in1_real,
  output logic [15:0]        bf_in1_imag,
  output logic [15:0]        bf_in2_real,
  output logic [15:0]        bf_in2_imag,
  output logic [15:0]        bf_twiddle_real,
  output logic [15:0]        bf_twiddle_imag,
  input  logic [15:0]        bf_out1_real,
  input  logic [15:0]        bf_out1_imag,
  input  logic [15:0]        bf_out2_real,
  input  logic [15:0]        bf_out2_imag,
  output logic               result_valid,
  output logic [15:0]        result_real,
  output logic [15:0]        result_imag,
  output logic [LOG2N-1:0]   result_index,
  input  logic               result_ready,
  output logic               busy,
  output logic               done
);

  localparam int BW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N_POINTS - 1);
  localparam logic [BW-1:0]    LAST_BF    = BW'(N_POINTS / 2 - 1);
  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_COMPUTE = 2'd1, S_UNLOAD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] load_cnt_q, load_cnt_d;
  logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
  logic [BW-1:0]    bfly_q, bfly_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic             done_q, done_d;
  logic [15:0]      mem_re_q [N_POINTS];
  logic [15:0]      mem_im_q [N_POINTS];
  logic [15:0]      mem_re_d [N_POINTS];
  logic [15:0]      mem_im_d [N_POINTS];

  logic [LOG2N-1:0] b_ext_s, half_s, mask_s, top_s, bot_s, tw_full_s;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Butterfly addressing: insert a zero bit at position stage into b to get the top index.
  always_comb begin
    b_ext_s   = {1'b0, bfly_q};
    half_s    = LOG2N'(1) << stage_q;
    mask_s    = half_s - LOG2N'(1);
    top_s     = ((b_ext_s & ~mask_s) << 1) | (b_ext_s & mask_s);
    bot_s     = top_s | half_s;
    tw_full_s = (b_ext_s & mask_s) << (SW'(BW) - stage_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      out_cnt_q  <= '0;
      bfly_q     <= '0;
      stage_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < N_POINTS; i++) begin
        mem_re_q[i] <= 16'h0000;
        mem_im_q[i] <= 16'h0000;
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      out_cnt_q  <= out_cnt_d;
      bfly_q     <= bfly_d;
      stage_q    <= stage_d;
      done_q     <= done_d;
      mem_re_q   <= mem_re_d;
      mem_im_q   <= mem_im_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:    if (sample_valid && load_cnt_q == LAST_IDX) state_d = S_COMPUTE; else state_d = S_LOAD;
      S_COMPUTE: if (bfly_q == LAST_BF && stage_q == LAST_STAGE) state_d = S_UNLOAD; else state_d = S_COMPUTE;
      S_UNLOAD:  if (result_ready && out_cnt_q == LAST_IDX) state_d = S_LOAD; else state_d = S_UNLOAD;
      default:   state_d = S_LOAD;
    endcase
  end

  // Counters and in-place RAM updates; butterfly results land at the edge closing each cycle.
  always_comb begin
    load_cnt_d = load_cnt_q;
    out_cnt_d  = out_cnt_q;
    bfly_d     = bfly_q;
    stage_d    = stage_q;
    done_d     = 1'b0;
    mem_re_d   = mem_re_q;
    mem_im_d   = mem_im_q;
    case (state_q)
      S_LOAD: begin
        if (sample_valid) begin
          mem_re_d[bit_rev(load_cnt_q)] = sample_real;
          mem_im_d[bit_rev(load_cnt_q)] = sample_imag;
          load_cnt_d = load_cnt_q + LOG2N'(1);
          bfly_d     = '0;
          stage_d    = '0;
        end else begin
          load_cnt_d = load_cnt_q;
        end
      end
      S_COMPUTE: begin
        mem_re_d[top_s] = bf_out1_real;
        mem_im_d[top_s] = bf_out1_imag;
        mem_re_d[bot_s] = bf_out2_real;
        mem_im_d[bot_s] = bf_out2_imag;
        if (bfly_q == LAST_BF) begin
          bfly_d  = '0;
          stage_d = (stage_q == LAST_STAGE) ? '0 : stage_q + SW'(1);
        end else begin
          bfly_d = bfly_q + BW'(1);
        end
      end
      S_UNLOAD: begin
        if (result_ready) begin
          out_cnt_d = out_cnt_q + LOG2N'(1);
          done_d    = (out_cnt_q == LAST_IDX);
        end else begin
          out_cnt_d = out_cnt_q;
        end
      end
      default: begin
        load_cnt_d = '0;
        out_cnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    sample_ready    = 1'b0;
    busy            = 1'b0;
    done            = done_q;
    twiddle_addr    = '0;
    bf_in1_real     = 16'h0000;
    bf_in1_imag     = 16'h0000;
    bf_in2_real     = 16'h0000;
    bf_in2_imag     = 16'h0000;
    bf_twiddle_real = 16'h0000;
    bf_twiddle_imag = 16'h0000;
    result_valid    = 1'b0;
    result_real     = 16'h0000;
    result_imag     = 16'h0000;
    result_index    = '0;
    case (state_q)
      S_LOAD: sample_ready = 1'b1;
      S_COMPUTE: begin
        busy            = 1'b1;
        twiddle_addr    = tw_full_s[BW-1:0];
        bf_in1_real     = mem_re_q[top_s];
        bf_in1_imag     = mem_im_q[top_s];
        bf_in2_real     = mem_re_q[bot_s];
        bf_in2_imag     = mem_im_q[bot_s];
        bf_twiddle_real = twiddle_real;
        bf_twiddle_imag = twiddle_imag;
      end
      S_UNLOAD: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        result_real  = mem_re_q[out_cnt_q];
        result_imag  = mem_im_q[out_cnt_q];
        result_index = out_cnt_q;
      end
      default: sample_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with a behavioural sign-magnitude butterfly
// and Q7.8 twiddle ROM.
module tb_fft_frame_sequencer;
  localparam int N = 16;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;
  logic sample_valid, sample_ready, result_valid, result_ready, busy, done;
  logic [15:0] sample_real, sample_imag;
  logic [L-2:0] twiddle_addr;
  logic [15:0] twiddle_real, twiddle_imag;
  logic [15:0] bf_in1_real, bf_in1_imag, bf_in2_real, bf_in2_imag;
  logic [15:0] bf_twiddle_real, bf_twiddle_imag;
  logic [15:0] bf_out1_real, bf_out1_imag, bf_out2_real, bf_out2_imag;
  logic [15:0] result_real, result_imag;
  logic [L-1:0] result_index;

  typedef struct { logic [15:0] re; logic [15:0] im; logic [L-1:0] idx; } exp_t;
  exp_t sb_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] rom_re [N/2];
  logic [15:0] rom_im [N/2];
  int tr, ti;

  fft_frame_sequencer #(.N_POINTS(N), .LOG2N(L)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_real(sample_real), .sample_imag(sample_imag),
    .sample_ready(sample_ready),
    .twiddle_addr(twiddle_addr), .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
    .bf_in1_real(bf_in1_real), .bf_in1_imag(bf_in1_imag),
    .bf_in2_real(bf_in2_real), .bf_in2_imag(bf_in2_imag),
    .bf_twiddle_real(bf_twiddle_real), .bf_twiddle_imag(bf_twiddle_imag),
    .bf_out1_real(bf_out1_real), .bf_out1_imag(bf_out1_imag),
    .bf_out2_real(bf_out2_real), .bf_out2_imag(bf_out2_imag),
    .result_valid(result_valid), .result_real(result_real), .result_imag(result_imag),
    .result_index(result_index), .result_ready(result_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int sm2i(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  function automatic logic [15:0] i2sm(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    return {(v < 0) && (m != 0), m[14:0]};
  endfunction

  function automatic int qmul(input int a, input int b);
    return (a * b) / 256;
  endfunction

  // Butterfly: out1 = a + W*b, out2 = a - W*b
  always_comb begin
    tr = qmul(sm2i(bf_in2_real), sm2i(bf_twiddle_real)) - qmul(sm2i(bf_in2_imag), sm2i(bf_twiddle_imag));
    ti = qmul(sm2i(bf_in2_real), sm2i(bf_twiddle_imag)) + qmul(sm2i(bf_in2_imag), sm2i(bf_twiddle_real));
    bf_out1_real = i2sm(sm2i(bf_in1_real) + tr);
    bf_out1_imag = i2sm(sm2i(bf_in1_imag) + ti);
    bf_out2_real = i2sm(sm2i(bf_in1_real) - tr);
    bf_out2_imag = i2sm(sm2i(bf_in1_imag) - ti);
  end

  assign twiddle_real = rom_re[twiddle_addr];
  assign twiddle_imag = rom_im[twiddle_addr];

  initial begin
    for (int k = 0; k < N / 2; k++) begin
      rom_re[k] = i2sm(int'($cos(2.0 * 3.14159265358979 * k / N) * 256.0));
      rom_im[k] = i2sm(-int'($sin(2.0 * 3.14159265358979 * k / N) * 256.0));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted bin is matched against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid && result_ready) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_bin: got index %0d with no expected entry", result_index);
      end else begin
        e = sb_q.pop_front();
        check("bin", {28'd0, result_index, result_real, result_imag}, {28'd0, e.idx, e.re, e.im});
      end
    end
  end

  task automatic push_frame(input int kind);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.idx = L'(i);
      e.im  = 16'h0000;
      if (kind == 0) e.re = 16'h0100;
      else e.re = (i == 0) ? 16'h1000 : 16'h0000;
      sb_q.push_back(e);
    end
  endtask

  // kind 0 impulse, 1 DC, 2 ramp x[k]=k.0
  task automatic load_frame(input int kind);
    for (int k = 0; k < N; k++) begin
      sample_valid = 1'b1;
      sample_imag  = 16'h0000;
      if (kind == 0) sample_real = (k == 0) ? 16'h0100 : 16'h0000;
      else if (kind == 1) sample_real = 16'h0100;
      else sample_real = 16'(k << 8);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    sample_real  = 16'h0000;
  endtask

  task automatic wait_done();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_seen", {63'd0, found}, 64'd1);
    if (found) begin
      check("done_busy_low", {63'd0, busy}, 64'd0);
      check("done_sample_ready", {63'd0, sample_ready}, 64'd1);
      check("done_all_bins", 64'(sb_q.size()), 64'd0);
      @(posedge clk); #1;
      check("done_one_cycle", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample_ready"}, {63'd0, sample_ready}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_result_valid"}, {63'd0, result_valid}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_bf_in"}, {bf_in1_real, bf_in2_real, bf_twiddle_real, 13'd0, twiddle_addr}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_real = 16'h0000;
    sample_imag = 16'h0000;
    result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    push_frame(0);
    load_frame(0);
    wait_done();

    push_frame(1);
    load_frame(1);
    cnt = 0;
    while (!result_valid && cnt < 80) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("dc_latency", 64'(cnt), 64'd32);
    wait_done();

    push_frame(0);
    load_frame(0);
    cnt = 0;
    while (!(result_valid && result_index == 4'd5) && cnt < 80) begin
      @(posedge clk); #1;
      cnt++;
    end
    result_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("bp_hold", {43'd0, result_valid, result_index, result_real}, {43'd0, 1'b1, 4'd5, 16'h0100});
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    wait_done();

    load_frame(2);
    repeat (4) @(posedge clk);
    #1;
    check("trace_b4", {29'd0, bf_in1_real, bf_in2_real, twiddle_addr}, {29'd0, 16'h0100, 16'h0900, 3'd0});
    repeat (27) @(posedge clk);
    #1;
    check("trace_last", {60'd0, busy, twiddle_addr}, {60'd0, 1'b1, 3'd7});
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    load_frame(1);
    repeat (9) @(posedge clk);
    #1;
    check("mid_compute_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_compute_rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    push_frame(1);
    load_frame(1);
    wait_done();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

In-place radix-2 decimation-in-time FFT sequencer that sits directly upstream of `butterfly_block` and consumes its results. It captures a frame of N complex samples in bit-reversed order into an internal register-file RAM, then drives `butterfly_block` with one butterfly per clock across all log2(N) stages, writing the results back in place. When the frame is finished, it streams the N frequency bins out in natural order over a valid/ready handshake. All data words are 16-bit sign-magnitude Q7.8 (bit 15 sign, bits 14:8 integer, bits 7:0 fraction); the sequencer only moves data and performs no arithmetic on it.

## Interface

Parameters:
- N_POINTS, 16, frame length; power of two, 4..64
- LOG2N, 4, log2(N_POINTS)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  input sample offered
- sample_real / sample_imag  in  16 each  input sample
- sample_ready  out  1  high in LOAD
- twiddle_addr  out  LOG2N-1  index k of W_N^k into an external asynchronous twiddle ROM
- twiddle_real / twiddle_imag  in  16 each  ROM data, valid in the same cycle as twiddle_addr
- bf_in1_real, bf_in1_imag, bf_in2_real, bf_in2_imag, bf_twiddle_real, bf_twiddle_imag  out  16 each  to butterfly_block inputs
- bf_out1_real, bf_out1_imag, bf_out2_real, bf_out2_imag  in  16 each  from butterfly_block outputs (combinational)
- result_valid  out  1  result bin offered
- result_real / result_imag  out  16 each  bin data
- result_index  out  LOG2N  bin number
- result_ready  in  1  consumer accepts bin
- busy  out  1  high in COMPUTE or UNLOAD
- done  out  1  one-cycle pulse after the last bin is accepted

## Operation

- RAM: N complex words, each stored as 32 flops (real and imaginary halves). Cleared to 0 by rst.
- FSM states LOAD, COMPUTE, UNLOAD. Reset enters LOAD.
- LOAD:
  - sample_ready=1.
  - On sample_valid&&sample_ready, write mem[bitrev(load_cnt)] and increment load_cnt.
  - On the N-th accepted sample, go to COMPUTE with stage s=0 and butterfly b=0.
- COMPUTE: one butterfly per cycle, b=0..N/2-1 inside each stage s=0..LOG2N-1. Address generation:
  - half=2^s
  - top=((b>>s)<<(s+1)) + (b&(half-1))
  - bot=top+half
  - twiddle_addr=(b&(half-1))<<(LOG2N-1-s)
- COMPUTE datapath:
  - bf_in1=mem[top], bf_in2=mem[bot], bf_twiddle=twiddle ROM data, all combinational from the current counters.
  - At the clock edge, mem[top]<=bf_out1 and mem[bot]<=bf_out2.
  - After b=N/2-1 of stage LOG2N-1, go to UNLOAD.
- UNLOAD:
  - result_valid=1; result_index=out_cnt; result = mem[out_cnt], natural order.
  - out_cnt advances on result_valid&&result_ready.
  - After index N-1 is accepted, go to LOAD and pulse done.
- Outside COMPUTE: all bf_* outputs and twiddle_addr are 0.
- Outside UNLOAD: result_valid=0, and result_real, result_imag and result_index are 0.
- sample_valid is ignored outside LOAD. result_ready is ignored outside UNLOAD.
- rst at any time, including mid-LOAD, mid-COMPUTE or mid-UNLOAD:
  - Returns immediately to LOAD; all counters zero, RAM cleared, done=0.
  - The partial frame is discarded.

## Timing

- Reset values: sample_ready=1 (LOAD); busy=0, result_valid=0, done=0; all data and address outputs 0.
- Sample throughput: one sample per cycle.
- COMPUTE length: exactly N/2*LOG2N cycles (32 for N=16).
- result_valid first rises exactly N/2*LOG2N cycles after the edge that accepted the last sample.
- busy rises in the first COMPUTE cycle and falls in the cycle done is high.
- UNLOAD with result_ready held high: one bin per cycle, N cycles.
- Backpressure: with result_ready low, result_valid, data and index hold stable.
- done is high for the single cycle following the final handshake. In that same cycle sample_ready=1, so a new frame may start immediately.
- The combinational path is RAM read -> butterfly_block -> RAM write, and must close in one clock.

## Test plan

Benches instantiate a real butterfly_block and a Q7.8 twiddle ROM model.

- **Reset:** assert rst asynchronously mid-cycle -> sample_ready=1, busy=0, result_valid=0, done=0, bf_* outputs=0, without waiting for a clock edge.
- **Impulse:** load x[0]=0x0100 (1.0), all other samples 0 -> 16 bins each result_real=0x0100 and result_imag=0x0000, result_index 0..15, then done high for one cycle.
- **DC:** all 16 samples 0x0100 -> bin 0 = 0x1000 (16.0); bins 1..15 = 0x0000; first result_valid exactly 32 cycles after the last sample edge.
- **Address trace:** load x[k]=k.0 (k<<8) ->
  - COMPUTE cycle 5 (stage 0, b=4): bf_in1_real=0x0100 (x[1] at address 8), bf_in2_real=0x0900 (x[9] at address 9), twiddle_addr=0.
  - Last COMPUTE cycle (stage 3, b=7): top=7, bot=15, twiddle_addr=7.
- **Backpressure:** drop result_ready for 3 cycles while result_index=5 -> result_valid stays 1 and index/data hold 5 for 3 cycles; all 16 bins are still delivered once, in order.
- **Reset mid-COMPUTE:** assert rst at COMPUTE cycle 10 -> LOAD and busy=0 immediately; a following DC frame produces bin 0 = 0x1000 and all other bins 0.
